meter_bank: RTL
===============

// Module: meter_bank
// PURPOSE
//   Parametrised multi-bay parking-meter core: NUM_BAYS independent countdown counters share one
//   coin/preset event bus addressed by bay_sel and decrement together on a 1 Hz tick enable.
//   A sequential double-dabble converter continuously produces BCD digits plus flash/expired
//   status for one display-selected bay. Sits between the debounce/single-pulse stage and the
//   seven-segment display FSM; all timing is clock-enable based (single clock domain).
// PARAMETERS
//   NUM_BAYS    4     number of independent meter counters (1..16)
//   BAY_W       2     width of bay_sel/disp_sel; 2**BAY_W >= NUM_BAYS
//   CNT_W       14    counter width in bits
//   DIGITS      4     BCD digits output; MAX_COUNT < 10**DIGITS
//   MAX_COUNT   9999  saturation ceiling
//   ADD0..ADD3  10,180,200,550  increments for add_req[0..3]
//   PRESET0     10    load value for preset_req[0]
//   PRESET1     205   load value for preset_req[1]
//   LOW_THRESH  200   count < LOW_THRESH asserts low/flash
// PORTS
//   clk          in   1          system clock
//   reset        in   1          asynchronous, active-high reset
//   sec_tick     in   1          1-cycle pulse, once per second; decrements all bays
//   add_req      in   4          1-cycle pulses (pre-debounced), add ADDn to bay_sel
//   preset_req   in   2          1-cycle pulses, load PRESETn into bay_sel
//   bay_sel      in   BAY_W      target bay for add_req/preset_req
//   disp_sel     in   BAY_W      bay shown on display
//   disp_bcd     out  4*DIGITS   BCD of displayed bay, MS digit in top nibble
//   disp_valid   out  1          1-cycle pulse when disp_bcd/disp_flash/disp_expired update
//   disp_flash   out  1          displayed bay count < LOW_THRESH (at snapshot)
//   disp_expired out  1          displayed bay count == 0 (at snapshot)
//   low          out  NUM_BAYS   per-bay count < LOW_THRESH, registered
//   expired      out  NUM_BAYS   per-bay count == 0, registered
// BEHAVIOUR
//   Reset: all counts 0; low and expired all 1; disp_bcd 0; disp_valid, disp_flash,
//     disp_expired 0; converter in LOAD. Reset mid-conversion aborts it, no disp_valid.
//   Per-bay next count, evaluated each cycle (one register update, no intermediate states):
//     base = preset_req ? preset value : count - (sec_tick && count>0)
//     next = min(base + sum of ADDn for every asserted add_req bit, MAX_COUNT)
//     Add/preset apply only to bay == bay_sel; sec_tick applies to all bays.
//     Preset priority: preset_req[1] over preset_req[0]; preset replaces count (no +1,
//     no same-cycle decrement), and same-cycle adds still accumulate on top.
//     Multiple add_req bits in one cycle sum. Sum uses CNT_W+3 bits; never wraps.
//     Count 0 with sec_tick stays 0 (no underflow).
//     bay_sel >= NUM_BAYS: add/preset ignored; tick still applies.
//   Events take effect on the next clock edge (1-cycle latency), independent of sec_tick.
//   low/expired registered from the updated count: valid the cycle after the count changes.
//   Converter FSM: LOAD -> SHIFT (CNT_W cycles) -> DONE -> LOAD, free-running.
//     LOAD: snapshot count[disp_sel], its low and expired flags; clear BCD shift register.
//     SHIFT: per cycle add 3 to each nibble >= 5, then shift left one bit in from snapshot MSB.
//     DONE: register disp_bcd/disp_flash/disp_expired, pulse disp_valid for 1 cycle.
//     Latency snapshot->disp_valid = CNT_W+1 cycles; period CNT_W+2 cycles.
//     disp_sel change mid-conversion takes effect at next LOAD; outputs hold between updates.
//     disp_sel >= NUM_BAYS: snapshot 0, expired=1, flash=1.
// TESTING
//   Reset, 20 sec_tick -> all counts 0, expired=all 1, disp_bcd=16'h0000, no underflow.
//   bay 2: add_req[3] x1 then add_req[0] -> bay2=560, others 0; disp_sel=2 -> disp_bcd=16'h0560.
//   bay 1: add_req=4'b1111 x4 in 4 cycles (3760) then add_req[3] x12 -> saturates at 9999.
//   bay 0: preset_req[1] with sec_tick same cycle -> 205 (no decrement); next tick -> 204, low=1.
//   bay 3 = 200, add_req[0] with sec_tick same cycle -> 209; low[3]=0 after 1 cycle.
//   Assert reset mid-SHIFT -> no disp_valid, all outputs to reset values; next valid after CNT_W+2.

Source files
------------

// File: rtl/meter_bank.sv
// meter_bank: a bank of parking-meter countdown counters that share one coin/preset bus,
// plus a free-running double-dabble converter that shows one selected bay as BCD digits.
module meter_bank #(
    parameter int NUM_BAYS   = 4,
    parameter int BAY_W      = 2,
    parameter int CNT_W      = 14,
    parameter int DIGITS     = 4,
    parameter int MAX_COUNT  = 9999,
    parameter int ADD0       = 10,
    parameter int ADD1       = 180,
    parameter int ADD2       = 200,
    parameter int ADD3       = 550,
    parameter int PRESET0    = 10,
    parameter int PRESET1    = 205,
    parameter int LOW_THRESH = 200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sec_tick,
    input  logic [3:0]            add_req,
    input  logic [1:0]            preset_req,
    input  logic [BAY_W-1:0]      bay_sel,
    input  logic [BAY_W-1:0]      disp_sel,
    output logic [4*DIGITS-1:0]   disp_bcd,
    output logic                  disp_valid,
    output logic                  disp_flash,
    output logic                  disp_expired,
    output logic [NUM_BAYS-1:0]   low,
    output logic [NUM_BAYS-1:0]   expired
);

    localparam int SUM_W    = CNT_W + 3;
    localparam int BCD_W    = 4 * DIGITS;
    localparam int CNT_BITS = $clog2(CNT_W + 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } conv_state_e;

    logic [CNT_W-1:0]    count_q [NUM_BAYS];
    logic [CNT_W-1:0]    count_d [NUM_BAYS];
    logic [NUM_BAYS-1:0] low_q, low_d;
    logic [NUM_BAYS-1:0] expired_q, expired_d;

    conv_state_e         state_q, state_d;
    logic [CNT_BITS-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]    snap_q, snap_d;
    logic                snap_flash_q, snap_flash_d;
    logic                snap_exp_q, snap_exp_d;
    logic [BCD_W-1:0]    shift_q, shift_d;
    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W-1:0]    disp_bcd_q, disp_bcd_d;
    logic                disp_valid_q, disp_valid_d;
    logic                disp_flash_q, disp_flash_d;
    logic                disp_expired_q, disp_expired_d;

    logic [SUM_W-1:0]    add_total;
    logic [CNT_W-1:0]    sel_count;

    // Total coin value requested this cycle; several buttons in one cycle simply add up.
    always_comb begin
        add_total = '0;
        if (add_req[0]) add_total = add_total + SUM_W'(ADD0);
        if (add_req[1]) add_total = add_total + SUM_W'(ADD1);
        if (add_req[2]) add_total = add_total + SUM_W'(ADD2);
        if (add_req[3]) add_total = add_total + SUM_W'(ADD3);
    end

    // Next count per bay: preset replaces (or tick decrements) the count, adds go on top, then clamp.
    always_comb begin : next_count
        logic [SUM_W-1:0] sum;
        for (int b = 0; b < NUM_BAYS; b++) begin
            sum = {3'b000, count_q[b]};
            if (sec_tick && (count_q[b] != '0)) begin
                sum = sum - SUM_W'(1);
            end
            if (bay_sel == BAY_W'(b)) begin
                if (preset_req[1]) begin
                    sum = SUM_W'(PRESET1);
                end else if (preset_req[0]) begin
                    sum = SUM_W'(PRESET0);
                end
                sum = sum + add_total;
            end
            if (sum > SUM_W'(MAX_COUNT)) begin
                count_d[b] = CNT_W'(MAX_COUNT);
            end else begin
                count_d[b] = sum[CNT_W-1:0];
            end
            low_d[b]     = count_q[b] < CNT_W'(LOW_THRESH);
            expired_d[b] = count_q[b] == '0;
        end
    end

    // Count of the bay chosen for display; an unpopulated bay reads as zero.
    always_comb begin
        sel_count = '0;
        for (int b = 0; b < NUM_BAYS; b++) begin
            if (disp_sel == BAY_W'(b)) begin
                sel_count = count_q[b];
            end
        end
    end

    // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the next shift.
    always_comb begin
        bcd_adj = shift_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (shift_q[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = shift_q[4*d +: 4] + 4'd3;
            end
        end
    end

    // Converter sequencing: snapshot, shift CNT_W bits through the BCD register, publish.
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        snap_d         = snap_q;
        snap_flash_d   = snap_flash_q;
        snap_exp_d     = snap_exp_q;
        shift_d        = shift_q;
        disp_bcd_d     = disp_bcd_q;
        disp_flash_d   = disp_flash_q;
        disp_expired_d = disp_expired_q;
        disp_valid_d   = 1'b0;
        case (state_q)
            ST_LOAD: begin
                snap_d       = sel_count;
                snap_flash_d = sel_count < CNT_W'(LOW_THRESH);
                snap_exp_d   = sel_count == '0;
                shift_d      = '0;
                bit_cnt_d    = '0;
                state_d      = ST_SHIFT;
            end
            ST_SHIFT: begin
                shift_d   = (bcd_adj << 1) | {{(BCD_W-1){1'b0}}, snap_q[CNT_W-1]};
                snap_d    = snap_q << 1;
                bit_cnt_d = bit_cnt_q + CNT_BITS'(1);
                if (bit_cnt_q == CNT_BITS'(CNT_W - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                disp_bcd_d     = shift_q;
                disp_flash_d   = snap_flash_q;
                disp_expired_d = snap_exp_q;
                disp_valid_d   = 1'b1;
                state_d        = ST_LOAD;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // All state registers; reset leaves every bay empty and flagged expired/low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NUM_BAYS; b++) begin
                count_q[b] <= '0;
            end
            low_q          <= '1;
            expired_q      <= '1;
            state_q        <= ST_LOAD;
            bit_cnt_q      <= '0;
            snap_q         <= '0;
            snap_flash_q   <= 1'b0;
            snap_exp_q     <= 1'b0;
            shift_q        <= '0;
            disp_bcd_q     <= '0;
            disp_valid_q   <= 1'b0;
            disp_flash_q   <= 1'b0;
            disp_expired_q <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_BAYS; b++) begin
                count_q[b] <= count_d[b];
            end
            low_q          <= low_d;
            expired_q      <= expired_d;
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            snap_q         <= snap_d;
            snap_flash_q   <= snap_flash_d;
            snap_exp_q     <= snap_exp_d;
            shift_q        <= shift_d;
            disp_bcd_q     <= disp_bcd_d;
            disp_valid_q   <= disp_valid_d;
            disp_flash_q   <= disp_flash_d;
            disp_expired_q <= disp_expired_d;
        end
    end

    assign disp_bcd     = disp_bcd_q;
    assign disp_valid   = disp_valid_q;
    assign disp_flash   = disp_flash_q;
    assign disp_expired = disp_expired_q;
    assign low          = low_q;
    assign expired      = expired_q;

endmodule
